obi_mem_arb2: RTL and testbench
===============================

Name: obi_mem_arb2

Overview:
Two-port OBI subordinate front-end that shares one single-port 32-bit word-aligned data/instruction memory between two managers (m0 = instruction fetch, m1 = load/store unit).
- Performs fair round-robin arbitration of address phases.
- Drives the memory's write/byte-enable/address lines.
- Registers read data and error into an OBI response phase one cycle after grant.
- Rejects out-of-range addresses.
- Sits between the core's OBI managers and the memory macro.

Parameters:
MEM_WIDTH, 6, log2 of word count; in-range address bits are [MEM_WIDTH+1:0].
ERR_RDATA, 32'hDEADBEEF, rdata returned on an error response.

Ports:
clk  in  1  clock; all state on rising edge.
reset  in  1  asynchronous, active-high reset.
mP_req_i  in  1  address-phase request (P in {0,1}, each port replicated).
mP_gnt_o  out  1  grant; the address phase is accepted on req & gnt.
mP_addr_i  in  32  byte address.
mP_we_i  in  1  1 = write.
mP_be_i  in  4  byte enables.
mP_wdata_i  in  32  write data.
mP_rvalid_o  out  1  response valid, one-cycle pulse.
mP_rdata_o  out  32  read data, valid with rvalid.
mP_err_o  out  1  error, valid with rvalid.
mem_we_o  out  1  memory write enable.
mem_be_o  out  4  memory byte enable.
mem_a_o  out  32  memory address.
mem_wd_o  out  32  memory write data.
mem_rd_i  in  32  memory combinational read data.
mem_err_i  in  1  memory error (illegal byte-enable pattern).

Behaviour:
Reset values:
- All mP_rvalid_o = 0, mP_rdata_o = 0, mP_err_o = 0.
- prio = 0 (m0 wins the first tie).

Arbitration (combinational, sub-module rr_arb2):
- Only one port requesting: it is granted in the same cycle.
- Both requesting: the port indicated by prio is granted.
- prio updates on every accepted transfer to the other port (prio <= ~granted_idx); no update when idle.
- Exactly one gnt is high at most. No port waits more than 1 cycle while the other is requesting.
- gnt never depends on rvalid state. There is no rready; managers must accept a response the cycle it appears.

Memory drive:
- Granted port's be/addr/wdata are routed to mem_*.
- mem_we_o = granted we & in_range.
- Idle: mem_we_o = 0, mem_be_o = 4'b1111, mem_a_o = 0, mem_wd_o = 0. This keeps mem_err_i low.

Range check:
- in_range = (addr[31:MEM_WIDTH+2] == 0).
- Out-of-range accesses: write suppressed; response err = 1.

Response (1-cycle latency):
- On the accept edge, granted port's rvalid <= 1; the other port's rvalid <= 0.
- rdata <= (err ? ERR_RDATA : mem_rd_i). Writes also return mem_rd_i; managers ignore it.
- err <= mem_err_i | ~in_range.
- Without an accept, rvalid <= 0; rdata/err hold.
- Back-to-back: a port may be granted on consecutive cycles, giving consecutive rvalid pulses. Responses stay in order per port.

Boundary conditions:
- Write and subsequent read to the same word on consecutive cycles: the read returns the new data (memory written at the accept edge).
- Reset asserted mid-transfer: pending rvalid cleared immediately (asynchronously); no response is ever delivered for that access. prio returns to 0.
- req dropped without gnt: legal here; no state change.

Decomposition:
Package obi_mem_pkg:
- obi_req_t struct {req, we, be[3:0], addr[31:0], wdata[31:0]}.
- obi_rsp_t struct {gnt, rvalid, rdata[31:0], err}.
- Constants IDLE_BE = 4'b1111 and ERR_RDATA_DEF = 32'hDEADBEEF.

Sub-module rr_arb2:
- Inputs: clk, reset, req[1:0], accept.
- Outputs: gnt[1:0], idx.
- Owns the prio flop.

Top level: mux, range check and response registers.

Test Plan:
1. Reset asserted with m0 rvalid pending -> all rvalid/rdata/err = 0 immediately; after release, the first tie grants m0.
2. m1 writes 0xCAFEF00D, be=1111, addr 0x10; next cycle m1 reads addr 0x10 -> rvalid one cycle after each grant; rdata = 0xCAFEF00D, err = 0.
3. m0 and m1 both request continuously for 6 cycles -> grants alternate m0,m1,m0,m1,m0,m1; each rvalid follows its grant by exactly 1 cycle.
4. m1 reads addr 0x0000_0100 (out of range, MEM_WIDTH=6) -> mem_we_o = 0, rvalid with err = 1, rdata = 0xDEADBEEF.
5. m1 writes with be=4'b0101 (illegal, mem_err_i = 1) -> err = 1, rdata = 0xDEADBEEF; m0 meanwhile idle sees no rvalid.
6. No requests for 4 cycles -> mem_be_o = 1111, mem_we_o = 0, no rvalid; prio unchanged.

Source files
------------

// File: rtl/obi_mem_pkg.sv
// Shared types and constants for the two-port OBI memory front-end.
package obi_mem_pkg;

   localparam int unsigned ADDR_W = 32;
   localparam int unsigned DATA_W = 32;
   localparam int unsigned BE_W   = 4;

   localparam logic [BE_W-1:0]   IDLE_BE       = 4'b1111;
   localparam logic [DATA_W-1:0] ERR_RDATA_DEF = 32'hDEADBEEF;

   typedef struct packed {
      logic              req;
      logic              we;
      logic [BE_W-1:0]   be;
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] wdata;
   } obi_req_t;

   typedef struct packed {
      logic              gnt;
      logic              rvalid;
      logic [DATA_W-1:0] rdata;
      logic              err;
   } obi_rsp_t;

   // True when every address bit above the word-count range is zero.
   function automatic logic addr_in_range(input logic [ADDR_W-1:0] addr,
                                          input int unsigned mem_width);
      return (addr >> (mem_width + 2)) == '0;
   endfunction

endpackage

// File: rtl/obi_mem_arb2_if.sv
// OBI address/response channel between one manager and the memory front-end.
interface obi_mem_if;
   import obi_mem_pkg::*;

   logic              req;
   logic              gnt;
   logic [ADDR_W-1:0] addr;
   logic              we;
   logic [BE_W-1:0]   be;
   logic [DATA_W-1:0] wdata;
   logic              rvalid;
   logic [DATA_W-1:0] rdata;
   logic              err;

   modport master (output req, addr, we, be, wdata,
                   input  gnt, rvalid, rdata, err);

   modport slave  (input  req, addr, we, be, wdata,
                   output gnt, rvalid, rdata, err);

endinterface

// File: rtl/obi_mem_arb2_rr_arb2.sv
// Two-requester round-robin arbiter; prio names the port that wins a tie.
module rr_arb2 (
   input  logic       clk,
   input  logic       reset,
   input  logic [1:0] req,
   input  logic       accept,
   output logic [1:0] gnt,
   output logic       idx
);

   logic prio;

   // Pick the winner: a lone requester, or prio on a tie.
   always_comb begin
      idx = 1'b0;
      gnt = 2'b00;
      if (req == 2'b11) idx = prio;
      else              idx = req[1];
      if (req[idx]) gnt[idx] = 1'b1;
   end

   // Hand the next tie to the port that was not just served.
   always_ff @(posedge clk or posedge reset) begin
      if (reset)       prio <= 1'b0;
      else if (accept) prio <= ~idx;
   end

endmodule

// File: rtl/obi_mem_arb2.sv
// Shares one single-port word memory between two OBI managers
// (m0 = instruction fetch, m1 = load/store) with a 1-cycle response.
module obi_mem_arb2
   import obi_mem_pkg::*;
#(
   parameter int unsigned       MEM_WIDTH = 6,
   parameter logic [DATA_W-1:0] ERR_RDATA = ERR_RDATA_DEF
) (
   input  logic              clk,
   input  logic              reset,
   obi_mem_if.slave          m0,
   obi_mem_if.slave          m1,
   output logic              mem_we,
   output logic [BE_W-1:0]   mem_be,
   output logic [ADDR_W-1:0] mem_a,
   output logic [DATA_W-1:0] mem_wd,
   input  logic [DATA_W-1:0] mem_rd,
   input  logic              mem_err
);

   obi_req_t          req_p [2];
   obi_req_t          sel;
   logic [1:0]        gnt;
   logic              idx;
   logic              accept;
   logic              in_range;
   logic              rsp_err;
   logic [DATA_W-1:0] rsp_rdata;

   logic [1:0]        rvalid_q;
   logic [1:0]        err_q;
   logic [DATA_W-1:0] rdata_q [2];

   // Gather both managers' address phases into request structs.
   always_comb begin
      req_p[0].req   = m0.req;
      req_p[0].we    = m0.we;
      req_p[0].be    = m0.be;
      req_p[0].addr  = m0.addr;
      req_p[0].wdata = m0.wdata;
      req_p[1].req   = m1.req;
      req_p[1].we    = m1.we;
      req_p[1].be    = m1.be;
      req_p[1].addr  = m1.addr;
      req_p[1].wdata = m1.wdata;
   end

   rr_arb2 u_arb (
      .clk    (clk),
      .reset  (reset),
      .req    ({req_p[1].req, req_p[0].req}),
      .accept (accept),
      .gnt    (gnt),
      .idx    (idx)
   );

   // Select the granted request and derive the response it will produce.
   always_comb begin
      sel       = req_p[idx];
      accept    = sel.req & gnt[idx];
      in_range  = addr_in_range(sel.addr, MEM_WIDTH);
      rsp_err   = mem_err | ~in_range;
      rsp_rdata = rsp_err ? ERR_RDATA : mem_rd;
   end

   // Route the granted port to the memory; park on a benign pattern when idle.
   always_comb begin
      mem_we = 1'b0;
      mem_be = IDLE_BE;
      mem_a  = '0;
      mem_wd = '0;
      if (accept) begin
         mem_we = sel.we & in_range;
         mem_be = sel.be;
         mem_a  = sel.addr;
         mem_wd = sel.wdata;
      end
   end

   // Response registers: one-cycle rvalid pulse; data and error hold between pulses.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rvalid_q <= 2'b00;
         err_q    <= 2'b00;
         for (int p = 0; p < 2; p++) rdata_q[p] <= '0;
      end else begin
         rvalid_q <= 2'b00;
         if (accept) begin
            rvalid_q[idx] <= 1'b1;
            err_q[idx]    <= rsp_err;
            rdata_q[idx]  <= rsp_rdata;
         end
      end
   end

   // Drive the manager-facing response signals.
   always_comb begin
      m0.gnt    = gnt[0];
      m0.rvalid = rvalid_q[0];
      m0.rdata  = rdata_q[0];
      m0.err    = err_q[0];
      m1.gnt    = gnt[1];
      m1.rvalid = rvalid_q[1];
      m1.rdata  = rdata_q[1];
      m1.err    = err_q[1];
   end

endmodule

// File: tb/tb_obi_mem_arb2.sv
// Self-checking bench for obi_mem_arb2: directed scenarios then random traffic
// against a transaction-level reference model.
module tb_obi_mem_arb2;
   import obi_mem_pkg::*;

   logic        clk   = 1'b0;
   logic        reset = 1'b0;
   logic        mem_we;
   logic [3:0]  mem_be;
   logic [31:0] mem_a;
   logic [31:0] mem_wd;
   logic [31:0] mem_rd;
   logic        mem_err;

   obi_mem_if m0_bus ();
   obi_mem_if m1_bus ();

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   obi_mem_arb2 #(.MEM_WIDTH(6), .ERR_RDATA(32'hDEADBEEF)) dut (
      .clk     (clk),
      .reset   (reset),
      .m0      (m0_bus),
      .m1      (m1_bus),
      .mem_we  (mem_we),
      .mem_be  (mem_be),
      .mem_a   (mem_a),
      .mem_wd  (mem_wd),
      .mem_rd  (mem_rd),
      .mem_err (mem_err)
   );

   // Memory macro: combinational read, byte-masked write, illegal be flagged.
   logic [31:0] mem_arr [64];

   function automatic logic be_legal(input logic [3:0] be);
      case (be)
         4'b1111, 4'b0011, 4'b1100,
         4'b0001, 4'b0010, 4'b0100, 4'b1000: return 1'b1;
         default:                            return 1'b0;
      endcase
   endfunction

   assign mem_rd  = mem_arr[mem_a[7:2]];
   assign mem_err = !be_legal(mem_be);

   always @(posedge clk) begin
      if (mem_we && be_legal(mem_be))
         for (int b = 0; b < 4; b++)
            if (mem_be[b]) mem_arr[mem_a[7:2]][8*b +: 8] <= mem_wd[8*b +: 8];
   end

   // Reference model state.
   logic [31:0] shadow [64];
   int          last_g;
   logic [1:0]  exp_rv;
   logic [31:0] exp_rd  [2];
   logic        exp_err [2];
   logic [1:0]  obs_gnt;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic check_rsp();
      chk("m0_rvalid", 32'(m0_bus.rvalid), 32'(exp_rv[0]));
      chk("m0_rdata",  m0_bus.rdata,       exp_rd[0]);
      chk("m0_err",    32'(m0_bus.err),    32'(exp_err[0]));
      chk("m1_rvalid", 32'(m1_bus.rvalid), 32'(exp_rv[1]));
      chk("m1_rdata",  m1_bus.rdata,       exp_rd[1]);
      chk("m1_err",    32'(m1_bus.err),    32'(exp_err[1]));
   endtask

   task automatic drive_idle();
      m0_bus.req = 1'b0; m0_bus.we = 1'b0; m0_bus.be = 4'h0; m0_bus.addr = '0; m0_bus.wdata = '0;
      m1_bus.req = 1'b0; m1_bus.we = 1'b0; m1_bus.be = 4'h0; m1_bus.addr = '0; m1_bus.wdata = '0;
   endtask

   // Reset in the middle of a cycle; response state must clear at once.
   task automatic apply_reset();
      drive_idle();
      reset = 1'b1;
      #1;
      exp_rv     = 2'b00;
      exp_rd[0]  = '0; exp_rd[1]  = '0;
      exp_err[0] = 1'b0; exp_err[1] = 1'b0;
      last_g     = 1;
      check_rsp();
      @(posedge clk);
      @(posedge clk);
      #2 reset = 1'b0;
   endtask

   // One bus cycle: drive both managers, check against the model, advance.
   task automatic cycle(input logic r0, input logic we0, input logic [3:0] be0,
                        input logic [31:0] a0, input logic [31:0] wd0,
                        input logic r1, input logic we1, input logic [3:0] be1,
                        input logic [31:0] a1, input logic [31:0] wd1);
      int          g;
      logic        s_we;
      logic [3:0]  s_be;
      logic [31:0] s_a;
      logic [31:0] s_wd;
      logic        in_rng;
      logic        e;
      m0_bus.req = r0; m0_bus.we = we0; m0_bus.be = be0; m0_bus.addr = a0; m0_bus.wdata = wd0;
      m1_bus.req = r1; m1_bus.we = we1; m1_bus.be = be1; m1_bus.addr = a1; m1_bus.wdata = wd1;
      #3;
      check_rsp();
      if (r0 && r1)  g = (last_g == 0) ? 1 : 0;
      else if (r0)   g = 0;
      else if (r1)   g = 1;
      else           g = -1;
      obs_gnt = {m1_bus.gnt, m0_bus.gnt};
      chk("gnt", 32'(obs_gnt), (g < 0) ? 32'd0 : ((g == 0) ? 32'd1 : 32'd2));
      if (g < 0) begin
         chk("mem_we_idle", 32'(mem_we), 32'd0);
         chk("mem_be_idle", 32'(mem_be), 32'hF);
         chk("mem_a_idle",  mem_a,       32'd0);
         chk("mem_wd_idle", mem_wd,      32'd0);
         exp_rv = 2'b00;
      end else begin
         s_we   = (g == 0) ? we0 : we1;
         s_be   = (g == 0) ? be0 : be1;
         s_a    = (g == 0) ? a0  : a1;
         s_wd   = (g == 0) ? wd0 : wd1;
         in_rng = (s_a < 32'd256);
         e      = !in_rng || !be_legal(s_be);
         chk("mem_we", 32'(mem_we), 32'(s_we && in_rng));
         chk("mem_be", 32'(mem_be), 32'(s_be));
         chk("mem_a",  mem_a,       s_a);
         chk("mem_wd", mem_wd,      s_wd);
         exp_rv      = 2'b00;
         exp_rv[g]   = 1'b1;
         exp_err[g]  = e;
         exp_rd[g]   = e ? 32'hDEADBEEF : shadow[s_a[7:2]];
         if (s_we && in_rng && be_legal(s_be))
            for (int b = 0; b < 4; b++)
               if (s_be[b]) shadow[s_a[7:2]][8*b +: 8] = s_wd[8*b +: 8];
         last_g = g;
      end
      @(posedge clk);
      #1;
   endtask

   function automatic logic [3:0] rand_be();
      logic [3:0] legal [7];
      legal = '{4'b1111, 4'b0011, 4'b1100, 4'b0001, 4'b0010, 4'b0100, 4'b1000};
      if ($urandom_range(0, 9) == 0) return 4'($urandom);
      return legal[$urandom_range(0, 6)];
   endfunction

   function automatic logic [31:0] rand_addr();
      if ($urandom_range(0, 9) == 0) return $urandom | 32'h100;
      return 32'($urandom_range(0, 7)) << 2;
   endfunction

   initial begin
      logic [31:0] v;
      for (int i = 0; i < 64; i++) begin
         v = $urandom;
         mem_arr[i] = v;
         shadow[i]  = v;
      end
      drive_idle();
      #1;
      apply_reset();

      // Reset lands while an m0 response is pending; then the first tie goes to m0.
      cycle(1, 0, 4'hF, 32'h4, 32'h0, 0, 0, 4'hF, 32'h0, 32'h0);
      chk("t1_pending", 32'(m0_bus.rvalid), 32'd1);
      apply_reset();
      cycle(1, 0, 4'hF, 32'h8, 32'h0, 1, 0, 4'hF, 32'hC, 32'h0);
      chk("t1_tie_m0", 32'(obs_gnt), 32'd1);

      // Write then read the same word on consecutive cycles.
      cycle(0, 0, 4'hF, 32'h0, 32'h0, 1, 1, 4'hF, 32'h10, 32'hCAFEF00D);
      cycle(0, 0, 4'hF, 32'h0, 32'h0, 1, 0, 4'hF, 32'h10, 32'h0);
      chk("t2_rvalid", 32'(m1_bus.rvalid), 32'd1);
      chk("t2_rdata",  m1_bus.rdata,       32'hCAFEF00D);
      chk("t2_err",    32'(m1_bus.err),    32'd0);

      // Continuous contention alternates m0, m1, ...
      for (int i = 0; i < 6; i++) begin
         cycle(1, 0, 4'hF, 32'(i) << 2, 32'h0, 1, 0, 4'hF, 32'(i + 8) << 2, 32'h0);
         chk("t3_alt", 32'(obs_gnt), (i % 2 == 0) ? 32'd1 : 32'd2);
      end

      // Out-of-range write is suppressed; out-of-range read errors.
      cycle(0, 0, 4'hF, 32'h0, 32'h0, 1, 1, 4'hF, 32'h100, 32'h12345678);
      cycle(0, 0, 4'hF, 32'h0, 32'h0, 1, 0, 4'hF, 32'h100, 32'h0);
      chk("t4_err",   32'(m1_bus.err), 32'd1);
      chk("t4_rdata", m1_bus.rdata,    32'hDEADBEEF);

      // Illegal byte-enable pattern reported as an error; idle m0 stays quiet.
      cycle(0, 0, 4'hF, 32'h0, 32'h0, 1, 1, 4'b0101, 32'h14, 32'h55AA55AA);
      chk("t5_err",      32'(m1_bus.err),    32'd1);
      chk("t5_rdata",    m1_bus.rdata,       32'hDEADBEEF);
      chk("t5_m0_quiet", 32'(m0_bus.rvalid), 32'd0);

      // Idle cycles leave the tie priority where it was.
      for (int i = 0; i < 4; i++)
         cycle(0, 0, 4'hF, 32'h0, 32'h0, 0, 0, 4'hF, 32'h0, 32'h0);
      cycle(1, 0, 4'hF, 32'h18, 32'h0, 1, 0, 4'hF, 32'h1C, 32'h0);
      chk("t6_tie_m0", 32'(obs_gnt), 32'd1);

      // Random traffic with occasional resets.
      for (int i = 0; i < 400; i++) begin
         if ($urandom_range(0, 99) == 0) apply_reset();
         cycle(1'($urandom), 1'($urandom), rand_be(), rand_addr(), $urandom,
               1'($urandom), 1'($urandom), rand_be(), rand_addr(), $urandom);
      end
      cycle(0, 0, 4'hF, 32'h0, 32'h0, 0, 0, 4'hF, 32'h0, 32'h0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
